// File: rtl/nes_mapper_pkg.sv
// Shared constants for the NES mapper blocks: IRQ clock-source modes and
// default counter / A12 filter sizing.
package nes_mapper_pkg;

    typedef enum logic {
        MODE_SCANLINE = 1'b0,
        MODE_CPU      = 1'b1
    } mode_e;

    localparam int unsigned CNT_W_DEFAULT       = 8;
    localparam int unsigned A12_LOW_MIN_DEFAULT = 3;

endpackage

// File: rtl/a12_edge_filter.sv
// Synchronises PPU A12 into the m2 domain and emits one counter event per
// qualified rising edge (scanline mode) or per m2 cycle (CPU mode).
module a12_edge_filter
    import nes_mapper_pkg::*;
#(
    parameter int unsigned A12_LOW_MIN = A12_LOW_MIN_DEFAULT
) (
    input  logic m2,
    input  logic rst_n,
    input  logic ppu_a12,
    input  logic mode,
    output logic scan_event,
    output logic a12_sync
);

    localparam int unsigned LW = (A12_LOW_MIN < 1) ? 1 : $clog2(A12_LOW_MIN + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_MIN);

    logic          s1, s2, s3;
    logic [LW-1:0] low_cnt;
    mode_e         mode_q;
    logic          mode_change;

    assign mode_change = (mode_e'(mode) != mode_q);
    assign a12_sync    = s2;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            low_cnt <= '0;
            mode_q  <= MODE_SCANLINE;
        end else begin
            s1     <= ppu_a12;
            s2     <= s1;
            s3     <= s2;
            mode_q <= mode_e'(mode);
            if (mode_change || s2)
                low_cnt <= '0;
            else if (low_cnt < LOW_MAX)
                low_cnt <= low_cnt + 1'b1;
        end
    end

    // A mode switch suppresses the event for that cycle in either direction.
    always_comb begin
        scan_event = 1'b0;
        if (!mode_change) begin
            if (mode_q == MODE_CPU)
                scan_event = 1'b1;
            else
                scan_event = s2 && !s3 && (low_cnt >= LOW_MAX);
        end
    end

endmodule

// File: rtl/scanline_irq_timer.sv
// MMC3-style scanline IRQ counter: latch/reload/enable registers, down-counter
// clocked by filtered A12 rises or m2, and the active-low IRQ request.
module scanline_irq_timer
    import nes_mapper_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned A12_LOW_MIN = A12_LOW_MIN_DEFAULT,
    parameter bit          REV_A       = 1'b0
) (
    input  logic             m2,
    input  logic             rst_n,
    input  logic             ppu_a12,
    input  logic [CNT_W-1:0] data_in,
    input  logic             wr_latch,
    input  logic             wr_reload,
    input  logic             wr_enable,
    input  logic             wr_disable,
    input  logic             mode,
    output logic             irq_n,
    output logic [CNT_W-1:0] count_out
);

    logic             scan_event;
    logic [CNT_W-1:0] count, latch, next_count;
    logic             reload, enabled, pending;
    logic             reload_eff, use_reload, irq_hit;

    a12_edge_filter #(
        .A12_LOW_MIN (A12_LOW_MIN)
    ) u_filter (
        .m2         (m2),
        .rst_n      (rst_n),
        .ppu_a12    (ppu_a12),
        .mode       (mode),
        .scan_event (scan_event),
        .a12_sync   ()
    );

    // A reload strobe landing on an event is honoured by that same event.
    always_comb begin
        reload_eff = reload | wr_reload;
        use_reload = (count == '0) || reload_eff;
        next_count = use_reload ? latch : count - 1'b1;
        irq_hit    = scan_event && enabled && (next_count == '0) &&
                     (!REV_A || (count != '0) || reload_eff);
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            latch   <= '0;
            reload  <= 1'b0;
            enabled <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (wr_latch)
                latch <= data_in;

            if (scan_event) begin
                count  <= next_count;
                reload <= 1'b0;
            end else if (wr_reload) begin
                reload <= 1'b1;
            end

            if (wr_disable)
                enabled <= 1'b0;
            else if (wr_enable)
                enabled <= 1'b1;

            if (wr_disable)
                pending <= 1'b0;
            else if (irq_hit)
                pending <= 1'b1;
        end
    end

    assign irq_n     = ~pending;
    assign count_out = count;

endmodule

// File: tb/tb_scanline_irq_timer.sv
// Directed bench for scanline_irq_timer: rev B and rev A instances share
// stimulus and are checked every cycle against a pin-history based model.
module tb_scanline_irq_timer;
    import nes_mapper_pkg::*;

    localparam int CW   = 8;
    localparam int LMIN = 3;
    localparam int HN   = 4096;

    logic          m2 = 1'b0;
    logic          rst_n = 1'b0;
    logic          ppu_a12 = 1'b0;
    logic [CW-1:0] data_in = '0;
    logic          wr_latch = 1'b0, wr_reload = 1'b0, wr_enable = 1'b0, wr_disable = 1'b0;
    logic          mode = 1'b0;
    logic          irq_n0, irq_n1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 m2 = ~m2;

    scanline_irq_timer #(.CNT_W(CW), .A12_LOW_MIN(LMIN), .REV_A(1'b0)) u_rev_b (
        .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .data_in(data_in),
        .wr_latch(wr_latch), .wr_reload(wr_reload), .wr_enable(wr_enable),
        .wr_disable(wr_disable), .mode(mode), .irq_n(irq_n0), .count_out(cnt0)
    );

    scanline_irq_timer #(.CNT_W(CW), .A12_LOW_MIN(LMIN), .REV_A(1'b1)) u_rev_a (
        .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .data_in(data_in),
        .wr_latch(wr_latch), .wr_reload(wr_reload), .wr_enable(wr_enable),
        .wr_disable(wr_disable), .mode(mode), .irq_n(irq_n1), .count_out(cnt1)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin value sampled at edge k lives in p_hist[k+3]; edges count
    // from 1 after reset, and indices <= 0 stand for the cleared synchroniser.
    bit p_hist[HN];
    int n_edge, epoch;
    bit mode_prev;
    int m_cnt[2];
    int m_latch;
    bit m_rl[2], m_en[2], m_pend[2];

    task automatic model_reset();
        foreach (p_hist[i]) p_hist[i] = 1'b0;
        n_edge = 0; epoch = 0; mode_prev = 1'b0; m_latch = 0;
        for (int r = 0; r < 2; r++) begin
            m_cnt[r] = 0; m_rl[r] = 1'b0; m_en[r] = 1'b0; m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ev;
        int run, old, nw;
        bit rl, hit;
        n_edge++;
        ev = 1'b0;
        if (mode != mode_prev) begin
            epoch = n_edge;
        end else if (mode) begin
            ev = 1'b1;
        end else begin
            // Consecutive low samples seen by the filter since reset / mode switch.
            run = 0;
            for (int j = n_edge - 1; j > epoch; j--) begin
                if (p_hist[j + 1]) break;
                run++;
            end
            ev = p_hist[n_edge + 1] && !p_hist[n_edge] && (run >= LMIN);
        end
        p_hist[n_edge + 3] = ppu_a12;
        mode_prev = mode;
        for (int r = 0; r < 2; r++) begin
            old = m_cnt[r];
            rl  = m_rl[r] || wr_reload;
            hit = 1'b0;
            if (ev) begin
                nw = (old == 0 || rl) ? m_latch : old - 1;
                m_cnt[r] = nw;
                m_rl[r]  = 1'b0;
                hit = (nw == 0) && m_en[r] && (r == 0 || old != 0 || rl);
            end else if (wr_reload) begin
                m_rl[r] = 1'b1;
            end
            if (wr_disable) begin
                m_pend[r] = 1'b0;
                m_en[r]   = 1'b0;
            end else begin
                if (hit) m_pend[r] = 1'b1;
                if (wr_enable) m_en[r] = 1'b1;
            end
        end
        if (wr_latch) m_latch = int'(data_in);
    endtask

    always @(posedge m2) if (rst_n) model_step();
    always @(negedge rst_n) model_reset();

    always @(negedge m2) begin
        if (rst_n) begin
            check("count_rev_b", cnt0, m_cnt[0]);
            check("irq_n_rev_b", irq_n0, !m_pend[0]);
            check("count_rev_a", cnt1, m_cnt[1]);
            check("irq_n_rev_a", irq_n1, !m_pend[1]);
        end
    end

    task automatic step();
        @(posedge m2);
        #1;
        wr_latch = 1'b0; wr_reload = 1'b0; wr_enable = 1'b0; wr_disable = 1'b0;
    endtask

    // Leaves the caller one edge before the event edge of the rise.
    task automatic a12_pulse(input int low);
        ppu_a12 = 1'b0;
        repeat (low) step();
        ppu_a12 = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge m2);
        #1;
        check("reset_irq_n", irq_n0, 1);
        check("reset_count", cnt0, 0);
        rst_n = 1'b1;

        // Four scanlines from latch=3
        data_in = 8'd3; wr_latch = 1'b1; step();
        wr_reload = 1'b1; step();
        wr_enable = 1'b1; step();
        for (int k = 1; k <= 3; k++) begin
            a12_pulse(4); step(); step();
            check("scanline_count", cnt0, 4 - k);
        end
        a12_pulse(4);
        check("irq_before_4th", irq_n0, 1);
        step();
        check("irq_4th_rev_b", irq_n0, 0);
        check("irq_4th_rev_a", irq_n1, 0);
        check("count_4th", cnt0, 0);
        step();
        wr_disable = 1'b1; step();
        check("disable_rev_b", irq_n0, 1);
        check("disable_rev_a", irq_n1, 1);

        // Short low glitch must not count; a full low period must
        a12_pulse(2); step(); step();
        check("glitch_count", cnt0, 0);
        a12_pulse(3); step(); step();
        check("filtered_rise", cnt0, 3);

        // Disable on the zero-reaching event
        wr_enable = 1'b1; step();
        a12_pulse(4); step(); step();
        a12_pulse(4); step(); step();
        a12_pulse(4);
        wr_disable = 1'b1; step();
        check("dis_evt_count", cnt0, 0);
        check("dis_evt_rev_b", irq_n0, 1);
        check("dis_evt_rev_a", irq_n1, 1);
        step();

        // Latch write coincident with a reload event uses the old latch
        data_in = 8'd2; wr_latch = 1'b1; step();
        a12_pulse(4);
        data_in = 8'd5; wr_latch = 1'b1; step();
        check("old_latch", cnt0, 2);
        check("old_latch_a", cnt1, 2);
        step();

        // Latch = 0: rev B fires every event, rev A only on the reload
        data_in = 8'd0; wr_latch = 1'b1; step();
        wr_reload = 1'b1; wr_enable = 1'b1; step();
        a12_pulse(4); step(); step();
        check("l0_first_rev_b", irq_n0, 0);
        check("l0_first_rev_a", irq_n1, 0);
        for (int k = 0; k < 2; k++) begin
            wr_disable = 1'b1; step();
            wr_enable = 1'b1; step();
            a12_pulse(4); step(); step();
            check("l0_next_rev_b", irq_n0, 0);
            check("l0_next_rev_a", irq_n1, 1);
        end

        // CPU-cycle mode: IRQ 10 cycles after the reload strobe
        wr_disable = 1'b1; data_in = 8'd9; wr_latch = 1'b1; step();
        mode = 1'b1; step();
        step(); step();
        wr_reload = 1'b1; wr_enable = 1'b1;
        repeat (9) step();
        check("cpu_9_rev_b", irq_n0, 1);
        check("cpu_9_rev_a", irq_n1, 1);
        step();
        check("cpu_10_rev_b", irq_n0, 0);
        check("cpu_10_rev_a", irq_n1, 0);
        check("cpu_10_count", cnt0, 0);

        // Asynchronous reset mid-count
        repeat (3) step();
        check("pre_reset_count", cnt0, 7);
        check("pre_reset_irq", irq_n0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_count_b", cnt0, 0);
        check("async_count_a", cnt1, 0);
        check("async_irq_b", irq_n0, 1);
        check("async_irq_a", irq_n1, 1);

        // A12 already high at release: first rise is too early to count
        @(posedge m2);
        #1;
        mode = 1'b0; ppu_a12 = 1'b1; data_in = 8'd4; wr_latch = 1'b1; rst_n = 1'b1;
        repeat (4) step();
        check("early_rise_ignored", cnt0, 0);
        a12_pulse(3); step();
        check("first_valid_rise", cnt0, 4);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
